// File: rtl/uart_rx_ex_pkg.sv
// rtl/uart_rx_ex_pkg.sv - shared types and constants for the uart_rx_ex receiver
//
// Purpose: register addresses, parity/FSM enums, status/config bit positions
//          and the FIFO entry layout used by uart_rx_ex and uart_rx_ex_fifo.
// Ports:   none (package).
package uart_rx_ex_pkg;

  // Register map
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CONFIG = 2'd2;
  localparam logic [1:0] ADDR_THRESH = 2'd3;

  // FIFO entry: {frame_err, parity_err, data[8:0]}
  localparam int ENTRY_W = 11;

  // Data register read fields
  localparam int          RD_PAR_ERR    = 9;
  localparam int          RD_FRAME_ERR  = 10;
  localparam logic [31:0] RD_EMPTY_WORD = 32'h8000_0000;

  // Status register fields
  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_TIMEOUT   = 3;
  localparam int STAT_LEVEL_LSB = 16;

  // Config register fields
  localparam int CFG_DIV_LSB    = 0;
  localparam int CFG_PARITY_LSB = 16;
  localparam int CFG_TWO_STOP   = 18;
  localparam int CFG_IRQ_EN     = 19;

  // Divisors below this cannot produce a tick train, so writes are clamped up.
  localparam logic [15:0] MIN_DIVISOR = 16'd2;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } rx_state_e;

  // The raw config field keeps all four encodings for readback; 2'b11 acts as none.
  function automatic parity_e decode_parity(input logic [1:0] raw);
    case (raw)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_ex_fifo.sv
// rtl/uart_rx_ex_fifo.sv - show-ahead receive FIFO with drop-on-full reporting
//
// Purpose: synchronous FIFO of ENTRY_W-bit received-frame entries. The head
//          entry is always visible on pop_data (show-ahead).
// Ports:
//   i_clock, i_reset   clock, synchronous active-high reset
//   push, push_data    write an entry (dropped when full unless popping too)
//   pop                remove the head entry (ignored when empty)
//   pop_data           current head entry
//   empty, full, level occupancy
//   dropped            1-cycle pulse when a push was discarded
module uart_rx_ex_fifo
  import uart_rx_ex_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       push_data,
  input  logic                     pop,
  output logic [ENTRY_W-1:0]       pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     dropped
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_pop;
  logic               do_push;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees a slot first, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign dropped = push && !do_push;

  assign pop_data = mem[rd_ptr];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_ex.sv
// rtl/uart_rx_ex.sv - configurable 16x-oversampling UART receiver with FIFO and IRQ
//
// Purpose: receives serial frames (DATA_BITS data, optional parity, 1 or 2
//          stop bits) using a 3-sample majority vote per bit, queues them with
//          per-entry parity/framing flags, and raises a level interrupt.
// Optional: define UART_RX_TIMEOUT_EN to add the idle receive-timeout flag.
// Ports:
//   i_clock, i_reset       clock, synchronous active-high reset
//   i_request, i_rw        bus request (held until o_ready), 1 = write
//   i_address, i_wdata     register select, write data
//   o_rdata, o_ready       read data and completion (1 cycle after request)
//   o_interrupt            registered level interrupt
//   UART_RX                asynchronous serial input
module uart_rx_ex
  import uart_rx_ex_pkg::*;
#(
  parameter int          DATA_BITS     = 8,
  parameter int          FIFO_DEPTH    = 16,
  parameter logic [15:0] RESET_DIVISOR = 16'd325
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [1:0]  i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_interrupt,
  input  logic        UART_RX
);

  localparam int         LVL_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  // ---------------- input synchronizer and edge detect ----------------
  logic rx_meta, rx_sync, rx_prev, rx_fall;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev && !rx_sync;

  // ---------------- bus decode ----------------
  // o_ready is the registered request, so a low o_ready with a high request
  // marks the first cycle of a transaction: the only cycle with side effects.
  logic req_start, bus_rd, bus_wr;
  logic cfg_wr, thr_wr, fifo_pop, stat_rd;

  assign req_start = i_request && !o_ready;
  assign bus_rd    = req_start && !i_rw;
  assign bus_wr    = req_start && i_rw;
  assign cfg_wr    = bus_wr && (i_address == ADDR_CONFIG);
  assign thr_wr    = bus_wr && (i_address == ADDR_THRESH);
  assign fifo_pop  = bus_rd && (i_address == ADDR_DATA);
  assign stat_rd   = bus_rd && (i_address == ADDR_STATUS);

  // ---------------- configuration registers ----------------
  logic [15:0] divisor;
  logic [1:0]  parity_raw;
  logic        two_stop;
  logic        irq_en;
  logic [7:0]  threshold;
  logic [15:0] div_clamped;
  logic [7:0]  thr_clamped;
  parity_e     parity_mode;
  logic        parity_on;
  logic        unused_wdata;

  assign div_clamped  = (i_wdata[15:0] < MIN_DIVISOR) ? MIN_DIVISOR : i_wdata[15:0];
  assign thr_clamped  = (i_wdata[7:0] == 8'd0) ? 8'd1 : i_wdata[7:0];
  assign parity_mode  = decode_parity(parity_raw);
  assign parity_on    = (parity_mode != PAR_NONE);
  assign unused_wdata = ^i_wdata[31:20];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      divisor    <= RESET_DIVISOR;
      parity_raw <= 2'b00;
      two_stop   <= 1'b0;
      irq_en     <= 1'b0;
      threshold  <= 8'd1;
    end else begin
      if (cfg_wr) begin
        divisor    <= div_clamped;
        parity_raw <= i_wdata[CFG_PARITY_LSB +: 2];
        two_stop   <= i_wdata[CFG_TWO_STOP];
        irq_en     <= i_wdata[CFG_IRQ_EN];
      end
      if (thr_wr) threshold <= thr_clamped;
    end
  end

  // ---------------- oversample tick ----------------
  logic [15:0] tick_cnt;
  logic        tick;

  assign tick = (tick_cnt == 16'd0);

  always_ff @(posedge i_clock) begin
    if (i_reset)              tick_cnt <= RESET_DIVISOR - 16'd1;
    else if (cfg_wr)          tick_cnt <= div_clamped - 16'd1;
    else if (tick)            tick_cnt <= divisor - 16'd1;
    else                      tick_cnt <= tick_cnt - 16'd1;
  end

  // ---------------- receive FSM ----------------
  rx_state_e              state, state_next;
  logic [3:0]             samp_cnt;
  logic [3:0]             bit_cnt;
  logic [DATA_BITS-1:0]   data_r;
  logic                   samp7, samp8;
  logic                   par_err;
  logic                   ferr_r;
  logic                   maj, exp_par;
  logic                   eval_tick, end_tick;
  logic                   fsm_push, push_ferr;
  logic [8:0]             data9;
  logic [ENTRY_W-1:0]     push_entry;

  // Bit value is decided on the tick-9 sample using the stored 7 and 8 samples.
  assign maj       = (samp7 & samp8) | (samp7 & rx_sync) | (samp8 & rx_sync);
  assign eval_tick = tick && (samp_cnt == 4'd9);
  assign end_tick  = tick && (samp_cnt == 4'd15);
  assign exp_par   = (parity_mode == PAR_ODD) ? ~^data_r : ^data_r;
  assign data9     = 9'(data_r);
  assign push_entry = {push_ferr, par_err, data9};

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    fsm_push   = 1'b0;
    push_ferr  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_fall) state_next = ST_START;
      end
      ST_START: begin
        if (eval_tick && maj)  state_next = ST_IDLE;
        else if (end_tick)     state_next = ST_DATA;
      end
      ST_DATA: begin
        if (end_tick && (bit_cnt == LAST_BIT))
          state_next = parity_on ? ST_PARITY : ST_STOP1;
      end
      ST_PARITY: begin
        if (end_tick) state_next = ST_STOP1;
      end
      ST_STOP1: begin
        // Leaving at tick 9 of the last stop bit leaves time to catch the
        // next start edge of a back-to-back frame.
        if (eval_tick && !two_stop) begin
          fsm_push   = 1'b1;
          push_ferr  = !maj;
          state_next = ST_IDLE;
        end else if (end_tick) begin
          state_next = two_stop ? ST_STOP2 : ST_IDLE;
        end
      end
      ST_STOP2: begin
        if (eval_tick) begin
          fsm_push   = 1'b1;
          push_ferr  = ferr_r | !maj;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      samp_cnt <= 4'd0;
      bit_cnt  <= 4'd0;
      data_r   <= '0;
      samp7    <= 1'b1;
      samp8    <= 1'b1;
      par_err  <= 1'b0;
      ferr_r   <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (rx_fall) begin
        samp_cnt <= 4'd0;
        bit_cnt  <= 4'd0;
        data_r   <= '0;
        par_err  <= 1'b0;
        ferr_r   <= 1'b0;
      end
    end else if (tick) begin
      samp_cnt <= samp_cnt + 4'd1;
      if (samp_cnt == 4'd7) samp7 <= rx_sync;
      if (samp_cnt == 4'd8) samp8 <= rx_sync;
      if (samp_cnt == 4'd9) begin
        case (state)
          ST_DATA: begin
            for (int i = 0; i < DATA_BITS; i++)
              if (bit_cnt == 4'(i)) data_r[i] <= maj;
          end
          ST_PARITY: par_err <= (maj != exp_par);
          ST_STOP1:  ferr_r  <= !maj;
          default: ;
        endcase
      end
      if ((samp_cnt == 4'd15) && (state == ST_DATA)) bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // ---------------- FIFO ----------------
  logic [ENTRY_W-1:0] fifo_dout;
  logic               fifo_empty, fifo_full, fifo_drop;
  logic [LVL_W-1:0]   fifo_level;
  logic [8:0]         level9;
  logic [7:0]         level8;

  uart_rx_ex_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .push      (fsm_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level),
    .dropped   (fifo_drop)
  );

  // A 256-deep FIFO can hold a level that does not fit the 8-bit status field.
  assign level9 = 9'(fifo_level);
  assign level8 = level9[8] ? 8'hFF : level9[7:0];

  // ---------------- overrun ----------------
  logic overrun;

  always_ff @(posedge i_clock) begin
    if (i_reset) overrun <= 1'b0;
    else         overrun <= fifo_drop | (overrun & ~stat_rd);
  end

  // ---------------- receive timeout ----------------
  logic timeout_flag;

`ifdef UART_RX_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_BITS = 8'(4 * (DATA_BITS + 2));

  logic [3:0] to_tick_cnt;
  logic [7:0] to_bit_cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      to_tick_cnt  <= 4'd0;
      to_bit_cnt   <= 8'd0;
      timeout_flag <= 1'b0;
    end else if (fifo_empty || fifo_pop) begin
      to_tick_cnt  <= 4'd0;
      to_bit_cnt   <= 8'd0;
      timeout_flag <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && rx_fall) begin
        to_tick_cnt <= 4'd0;
        to_bit_cnt  <= 8'd0;
      end else if ((state == ST_IDLE) && tick) begin
        to_tick_cnt <= to_tick_cnt + 4'd1;
        if ((to_tick_cnt == 4'd15) && (to_bit_cnt != TIMEOUT_BITS))
          to_bit_cnt <= to_bit_cnt + 8'd1;
      end
      if (to_bit_cnt == TIMEOUT_BITS) timeout_flag <= 1'b1;
    end
  end
`else
  assign timeout_flag = 1'b0;
`endif

  // ---------------- read mux and bus response ----------------
  logic [31:0] rdata_next;

  always_comb begin
    rdata_next = 32'd0;
    case (i_address)
      ADDR_DATA: rdata_next = fifo_empty ? RD_EMPTY_WORD : 32'(fifo_dout);
      ADDR_STATUS: begin
        rdata_next[STAT_EMPTY]              = fifo_empty;
        rdata_next[STAT_FULL]               = fifo_full;
        rdata_next[STAT_OVERRUN]            = overrun;
        rdata_next[STAT_TIMEOUT]            = timeout_flag;
        rdata_next[STAT_LEVEL_LSB +: 8]     = level8;
      end
      ADDR_CONFIG: begin
        rdata_next[CFG_DIV_LSB +: 16]       = divisor;
        rdata_next[CFG_PARITY_LSB +: 2]     = parity_raw;
        rdata_next[CFG_TWO_STOP]            = two_stop;
        rdata_next[CFG_IRQ_EN]              = irq_en;
      end
      default: rdata_next[7:0] = threshold;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_ready     <= 1'b0;
      o_rdata     <= 32'd0;
      o_interrupt <= 1'b0;
    end else begin
      o_ready <= i_request;
      if (bus_rd) o_rdata <= rdata_next;
      o_interrupt <= irq_en && ((level9 >= {1'b0, threshold}) || overrun || timeout_flag);
    end
  end

endmodule
